fifo_serial_tx: RTL and testbench

//  Read-side consumer for the word FIFO. Pops one N-bit word whenever the FIFO is non-empty and

---
 rtl/fifo_serial_tx_pkg.sv | 21 ++
 rtl/fifo_serial_tx_if.sv | 23 ++
 rtl/fifo_serial_tx_baud.sv | 26 ++
 rtl/fifo_serial_tx.sv | 146 ++++++++++++++
 tb/tb_fifo_serial_tx.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and frame constants for the FIFO-fed serial transmitter.
package fifo_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } tx_state_t;

   localparam int START_BITS = 1;

   // Serial bit periods in one frame: start + data + optional parity + stop.
   function automatic int frame_bits(input int n, input int parity_en, input int stop_bits);
      return START_BITS + n + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus serial line and status, bundled as one interface.
// slave = transmitter side, master = FIFO/board side.
interface fifo_serial_tx_if #(
   parameter int N = 16
);
   logic         TX_EN;
   logic         EMPTY;
   logic [N-1:0] FIFO_DATA;
   logic         RE;
   logic         TX;
   logic         BUSY;
   logic         DONE;

   modport master (
      output TX_EN, EMPTY, FIFO_DATA,
      input  RE, TX, BUSY, DONE
   );

   modport slave (
      input  TX_EN, EMPTY, FIFO_DATA,
      output RE, TX, BUSY, DONE
   );
endinterface

// File: rtl/fifo_serial_tx_baud.sv
// Bit-period divider: tick marks the last clk of each serial bit period.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt_q;

   assign tick = !clear && (cnt_q == CW'(CLKS_PER_BIT - 1));

   // Count clk cycles within a bit; wrap on the terminal count, hold at 0 while cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO read-side consumer: pops one word per frame and shifts it out LSB-first
// with start bit, optional even parity and 1..2 stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for TX_EN && !EMPTY
// REQ    | RE high for this single cycle
// LOAD   | FIFO_DATA valid, captured at the end of this cycle
// START  | start bit (0)
// DATA   | N data bits, LSB first
// PARITY | even-parity bit
// STOP   | STOP_BITS stop bits (1), then re-arm or return to IDLE
module fifo_serial_tx
   import fifo_pkg::*;
#(
   parameter int N            = 16,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                clk,
   input  logic                reset,
   fifo_serial_tx_if.slave     bus
);
   localparam int BW = $clog2(N + 1);

   tx_state_t    state_q;
   logic [N-1:0] shreg_q;
   logic [N-1:0] shreg_d;
   logic         parity_q;
   logic [BW-1:0] bitcnt_q;
   logic         tx_q;
   logic         re_q;
   logic         busy_q;
   logic         done_q;
   logic         tick;
   logic         baud_clear;
   logic         start_ok;

   assign start_ok = bus.TX_EN && !bus.EMPTY;
   assign shreg_d  = shreg_q >> 1;

   // The divider only runs during bit-time states; START is entered from LOAD with
   // the divider already at zero, every later state change lands on a wrap.
   assign baud_clear = (state_q == IDLE) || (state_q == REQ) || (state_q == LOAD);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Frame sequencer with registered line, read-enable and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         parity_q <= 1'b0;
         bitcnt_q <= '0;
         tx_q     <= 1'b1;
         re_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         re_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  state_q <= REQ;
                  re_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            REQ: begin
               state_q <= LOAD;
            end
            LOAD: begin
               shreg_q  <= bus.FIFO_DATA;
               parity_q <= ^bus.FIFO_DATA;
               bitcnt_q <= '0;
               tx_q     <= 1'b0;
               state_q  <= START;
            end
            START: begin
               if (tick) begin
                  tx_q    <= shreg_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bitcnt_q == BW'(N - 1)) begin
                     bitcnt_q <= '0;
                     if (PARITY_EN != 0) begin
                        tx_q    <= parity_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     bitcnt_q <= bitcnt_q + 1'b1;
                     shreg_q  <= shreg_d;
                     tx_q     <= shreg_d[0];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bitcnt_q == BW'(STOP_BITS - 1)) begin
                     bitcnt_q <= '0;
                     done_q   <= 1'b1;
                     if (start_ok) begin
                        state_q <= REQ;
                        re_q    <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     bitcnt_q <= bitcnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.TX   = tx_q;
   assign bus.RE   = re_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: dut0 without parity, dut1 with even parity, both 4 clk/bit, 1 stop bit.
module tb_fifo_serial_tx;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fifo_serial_tx_if #(.N(16)) b0 ();
   fifo_serial_tx_if #(.N(16)) b1 ();

   fifo_serial_tx #(.N(16), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
      .clk (clk), .reset (reset), .bus (b0)
   );
   fifo_serial_tx #(.N(16), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
      .clk (clk), .reset (reset), .bus (b1)
   );

   int vectors = 0;
   int miscompares = 0;

   // FIFO contents and scoreboard of words expected on each serial line
   logic [15:0] fq0[$];
   logic [15:0] fq1[$];
   logic [15:0] exp0[$];
   logic [15:0] exp1[$];
   int          gapq0[$];

   int re_empty = 0;
   int re_dbl   = 0;
   int re_cnt[2];
   int done_cnt[2];
   bit prev_re[2];
   bit in_frame[2];
   int idx[2];
   int hi_run[2];
   int flen[2];
   logic [75:0] cap[2];
   logic [75:0] expv[2];

   // FIFO read port model: data appears the cycle after an RE-qualified edge
   always @(posedge clk) begin
      if (b0.RE) begin
         if (fq0.size() > 0) b0.FIFO_DATA <= fq0.pop_front();
         else re_empty++;
      end
      if (b1.RE) begin
         if (fq1.size() > 0) b1.FIFO_DATA <= fq1.pop_front();
         else re_empty++;
      end
   end

   always begin
      @(posedge clk);
      #2;
      b0.EMPTY = (fq0.size() == 0);
      b1.EMPTY = (fq1.size() == 0);
   end

   // Expected per-clk line waveform for one word (4 clk per bit)
   function automatic logic [75:0] build(input logic [15:0] w, input bit par);
      logic [18:0] bits;
      logic [75:0] v;
      int          nb;
      bits    = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < 16; i++) bits[1 + i] = w[i];
      if (par) begin
         bits[17] = ^w;
         bits[18] = 1'b1;
         nb = 19;
      end else begin
         bits[17] = 1'b1;
         nb = 18;
      end
      v = '0;
      for (int b = 0; b < nb; b++)
         for (int c = 0; c < 4; c++) v[b*4 + c] = bits[b];
      return v;
   endfunction

   // Line monitor: pops the scoreboard at each start bit and compares the whole frame
   always @(negedge clk) begin
      logic [1:0]  txv;
      logic [1:0]  rev;
      logic [1:0]  dnv;
      logic [15:0] w;
      bit          have;
      txv = {b1.TX, b0.TX};
      rev = {b1.RE, b0.RE};
      dnv = {b1.DONE, b0.DONE};
      for (int k = 0; k < 2; k++) begin
         if (rev[k]) begin
            re_cnt[k]++;
            if (prev_re[k]) re_dbl++;
         end
         prev_re[k] = rev[k];
         if (dnv[k]) done_cnt[k]++;
         if (reset) begin
            in_frame[k] = 0;
            hi_run[k]   = 0;
         end else if (!in_frame[k]) begin
            if (txv[k] == 1'b0) begin
               have = 0;
               w    = '0;
               if (k == 0 && exp0.size() > 0) begin w = exp0.pop_front(); have = 1; end
               if (k == 1 && exp1.size() > 0) begin w = exp1.pop_front(); have = 1; end
               vectors++;
               if (!have) begin
                  miscompares++;
                  $display("FAIL frame_unexpected dut%0d: got start bit, expected idle line", k);
               end else begin
                  expv[k]     = build(w, k == 1);
                  flen[k]     = (k == 1) ? 76 : 72;
                  cap[k]      = '0;
                  idx[k]      = 1;
                  in_frame[k] = 1;
                  if (k == 0) gapq0.push_back(hi_run[0]);
               end
            end else begin
               hi_run[k]++;
            end
         end else begin
            cap[k][idx[k]] = txv[k];
            idx[k]++;
            if (idx[k] == flen[k]) begin
               vectors++;
               if (cap[k] !== expv[k]) begin
                  miscompares++;
                  $display("FAIL frame_wave dut%0d: got %h expected %h", k, cap[k], expv[k]);
               end
               in_frame[k] = 0;
               hi_run[k]   = 0;
            end
         end
      end
   end

   task automatic push(input int k, input logic [15:0] w);
      if (k == 0) begin
         fq0.push_back(w);
         exp0.push_back(w);
         b0.EMPTY = 1'b0;
      end else begin
         fq1.push_back(w);
         exp1.push_back(w);
         b1.EMPTY = 1'b0;
      end
   endtask

   // Advance negedges until the line goes low (frame start) or the budget runs out
   task automatic wait_tx_low(input int k, input int limit, output bit ok);
      int c = 0;
      while (((k == 0) ? b0.TX : b1.TX) !== 1'b0 && c < limit) begin
         @(negedge clk);
         c++;
      end
      ok = (((k == 0) ? b0.TX : b1.TX) === 1'b0);
   endtask

   task automatic wait_done(input int k, input int limit, output bit ok);
      int c = 0;
      while (((k == 0) ? b0.DONE : b1.DONE) !== 1'b1 && c < limit) begin
         @(negedge clk);
         c++;
      end
      ok = (((k == 0) ? b0.DONE : b1.DONE) === 1'b1);
   endtask

   task automatic test_reset();
      bit ok;
      int bad;
      int r0;
      reset        = 1'b1;
      b0.TX_EN     = 1'b0;
      b1.TX_EN     = 1'b0;
      b0.EMPTY     = 1'b1;
      b1.EMPTY     = 1'b1;
      b0.FIFO_DATA = '0;
      b1.FIFO_DATA = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({b0.TX, b0.RE, b0.BUSY, b0.DONE} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_state dut0: got %b expected 1000", {b0.TX, b0.RE, b0.BUSY, b0.DONE});
      end
      vectors++;
      if ({b1.TX, b1.RE, b1.BUSY, b1.DONE} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_state dut1: got %b expected 1000", {b1.TX, b1.RE, b1.BUSY, b1.DONE});
      end
      reset = 1'b0;
      // start a frame of zeros, then reset in the middle of the data bits
      b0.TX_EN = 1'b1;
      push(0, 16'h0000);
      wait_tx_low(0, 20, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL reset_frame_start: got no start bit, expected TX low within 20 clk");
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (b0.TX !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pre_data: got TX=%b expected 0", b0.TX);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({b0.TX, b0.RE, b0.BUSY} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_async: got TX/RE/BUSY=%b expected 100", {b0.TX, b0.RE, b0.BUSY});
      end
      fq0.delete();
      exp0.delete();
      b0.EMPTY = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      r0  = re_cnt[0];
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (b0.TX !== 1'b1 || b0.BUSY !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0 || re_cnt[0] != r0) begin
         miscompares++;
         $display("FAIL reset_idle_hold: got %0d active cycles %0d RE, expected 0 and 0", bad, re_cnt[0] - r0);
      end
   endtask

   task automatic test_single_word();
      logic [17:0] seq;
      logic [17:0] want;
      int          r0, d0, dn;
      want = 18'b110100101110000110;
      r0 = re_cnt[0];
      d0 = done_cnt[0];
      b0.TX_EN = 1'b1;
      @(negedge clk);
      push(0, 16'hA5C3);
      @(negedge clk);
      vectors++;
      if ({b0.RE, b0.BUSY} !== 2'b11) begin
         miscompares++;
         $display("FAIL single_re_busy: got RE/BUSY=%b expected 11", {b0.RE, b0.BUSY});
      end
      @(negedge clk);
      vectors++;
      if ({b0.RE, b0.TX} !== 2'b01) begin
         miscompares++;
         $display("FAIL single_load: got RE/TX=%b expected 01", {b0.RE, b0.TX});
      end
      @(negedge clk);
      vectors++;
      if (b0.TX !== 1'b0) begin
         miscompares++;
         $display("FAIL single_latency: got TX=%b two clk after RE, expected 0", b0.TX);
      end
      seq = '0;
      dn  = 0;
      for (int c = 0; c < 72; c++) begin
         if (c % 4 == 2) seq[c/4] = b0.TX;
         if (b0.DONE) dn++;
         @(negedge clk);
      end
      vectors++;
      if (seq !== want) begin
         miscompares++;
         $display("FAIL single_bits: got %b expected %b", seq, want);
      end
      vectors++;
      if (dn != 0 || {b0.DONE, b0.BUSY} !== 2'b10) begin
         miscompares++;
         $display("FAIL single_done_edge: got early=%0d DONE/BUSY=%b expected 0 and 10", dn, {b0.DONE, b0.BUSY});
      end
      @(negedge clk);
      vectors++;
      if (b0.DONE !== 1'b0 || re_cnt[0] - r0 != 1 || done_cnt[0] - d0 != 1) begin
         miscompares++;
         $display("FAIL single_pulses: got DONE=%b RE=%0d DONE=%0d expected 0,1,1", b0.DONE, re_cnt[0] - r0, done_cnt[0] - d0);
      end
   endtask

   task automatic test_parity();
      logic [15:0] words[2];
      logic        pexp[2];
      logic        pbit;
      bit          ok;
      int          c;
      words[0] = 16'hA5C3; pexp[0] = 1'b0;
      words[1] = 16'h0001; pexp[1] = 1'b1;
      b1.TX_EN = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         push(1, words[i]);
         wait_tx_low(1, 10, ok);
         c    = 0;
         pbit = 1'bx;
         while (b1.DONE !== 1'b1 && c < 200) begin
            if (c == 70) pbit = b1.TX;
            @(negedge clk);
            c++;
         end
         vectors++;
         if (!ok || pbit !== pexp[i]) begin
            miscompares++;
            $display("FAIL parity_bit %h: got %b expected %b", words[i], pbit, pexp[i]);
         end
         vectors++;
         if (c != 76) begin
            miscompares++;
            $display("FAIL parity_frame_len %h: got %0d clk expected 76", words[i], c);
         end
      end
      b1.TX_EN = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int r0, ds, busy_low, c;
      bit started;
      gapq0.delete();
      r0       = re_cnt[0];
      ds       = 0;
      busy_low = 0;
      c        = 0;
      started  = 0;
      b0.TX_EN = 1'b1;
      @(negedge clk);
      push(0, 16'h1234);
      push(0, 16'hFFFF);
      push(0, 16'h8001);
      while (ds < 3 && c < 400) begin
         @(negedge clk);
         c++;
         if (b0.RE) started = 1;
         if (b0.DONE) ds++;
         if (started && !(b0.DONE && ds == 3) && b0.BUSY !== 1'b1) busy_low++;
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (ds != 3 || re_cnt[0] - r0 != 3) begin
         miscompares++;
         $display("FAIL b2b_counts: got DONE=%0d RE=%0d expected 3 and 3", ds, re_cnt[0] - r0);
      end
      vectors++;
      if (busy_low != 0) begin
         miscompares++;
         $display("FAIL b2b_busy: got %0d BUSY-low cycles expected 0", busy_low);
      end
      vectors++;
      if (gapq0.size() != 3 || gapq0[1] != 2 || gapq0[2] != 2) begin
         miscompares++;
         $display("FAIL b2b_gap: got %0d frames gaps %0d,%0d expected 3 frames gaps 2,2",
                  gapq0.size(), (gapq0.size() > 1) ? gapq0[1] : -1, (gapq0.size() > 2) ? gapq0[2] : -1);
      end
      vectors++;
      if (b0.BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_busy_end: got BUSY=%b expected 0", b0.BUSY);
      end
   endtask

   task automatic test_txen_drop();
      int r0, c;
      bit ok;
      r0 = re_cnt[0];
      b0.TX_EN = 1'b1;
      @(negedge clk);
      push(0, 16'h5A5A);
      push(0, 16'h00FF);
      wait_tx_low(0, 10, ok);
      b0.TX_EN = 1'b0;
      wait_done(0, 100, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL txen_drop_done: got no DONE expected one within 100 clk");
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (re_cnt[0] - r0 != 1 || {b0.BUSY, b0.TX} !== 2'b01) begin
         miscompares++;
         $display("FAIL txen_drop_hold: got RE=%0d BUSY/TX=%b expected 1 and 01", re_cnt[0] - r0, {b0.BUSY, b0.TX});
      end
      b0.TX_EN = 1'b1;
      c = 0;
      while (b0.TX !== 1'b0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      vectors++;
      if (c != 3) begin
         miscompares++;
         $display("FAIL txen_restart: got TX low after %0d clk expected 3", c);
      end
      wait_done(0, 100, ok);
      @(negedge clk);
      vectors++;
      if (!ok || re_cnt[0] - r0 != 2) begin
         miscompares++;
         $display("FAIL txen_second: got done=%0d RE=%0d expected 1 and 2", ok, re_cnt[0] - r0);
      end
   endtask

   task automatic test_empty_hold();
      int r0, bad;
      bit ok;
      r0  = re_cnt[0];
      bad = 0;
      b0.TX_EN = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (b0.RE !== 1'b0 || b0.TX !== 1'b1) bad++;
      end
      vectors++;
      if (bad != 0 || re_cnt[0] != r0) begin
         miscompares++;
         $display("FAIL empty_hold: got %0d active cycles %0d RE expected 0 and 0", bad, re_cnt[0] - r0);
      end
      push(0, 16'h3C3C);
      @(negedge clk);
      vectors++;
      if (b0.RE !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_release: got RE=%b expected 1", b0.RE);
      end
      wait_done(0, 100, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL empty_release_done: got no DONE expected one within 100 clk");
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_parity();
      test_back_to_back();
      test_txen_drop();
      test_empty_hold();
      repeat (5) @(negedge clk);
      vectors++;
      if (exp0.size() + exp1.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d words not transmitted expected 0", exp0.size() + exp1.size());
      end
      vectors++;
      if (re_dbl != 0 || re_empty != 0) begin
         miscompares++;
         $display("FAIL re_rules: got %0d back-to-back RE %0d RE-on-empty expected 0 and 0", re_dbl, re_empty);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
